l2_vc_requester: RTL and testbench
==================================

Name: l2_vc_requester

Overview:
- Initiator-side controller between the L2 miss path and the victim cache (VC) plus physical memory.
- On an L2 miss it does three things in order:
  - pushes the L2 victim line into the VC (write) when one exists;
  - probes the VC for the missing line (read);
  - on a VC miss, fetches the line from physical memory.
- It then returns the line to L2 as a single-cycle fill.
- It also keeps saturating VC hit/miss statistics.

Parameters:
ADDR_W, 16, byte address width (lc3b address space)
LINE_W, 128, cache line width in bits
CNT_W, 16, width of statistics counters

Ports:
clk  in  1  system clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
miss_req  in  1  L2 requests a line; sampled only in IDLE
miss_addr  in  ADDR_W  line-aligned address of the missing line
evict_valid  in  1  L2 has a victim line to displace with this miss
evict_addr  in  ADDR_W  victim line address
evict_data  in  LINE_W  victim line data
evict_dirty  in  1  victim line dirty in L2
busy  out  1  high in every state except IDLE
fill_valid  out  1  one-cycle pulse: fill_data/fill_dirty valid for L2
fill_data  out  LINE_W  returned line
fill_dirty  out  1  returned line is dirty (VC hit with dirty entry), else 0
vc_write  out  1  write request to VC, held until vc_resp
vc_read  out  1  read/probe request to VC, held until vc_resp
vc_addr  out  ADDR_W  VC request address
vc_wdata  out  LINE_W  VC write data
vc_wdirty  out  1  dirty flag for VC write
vc_resp  in  1  VC completion; may assert in the same cycle the request is first driven
vc_hit  in  1  valid with vc_resp on read: line present
vc_rdata  in  LINE_W  valid with vc_resp on read hit
vc_rdirty  in  1  valid with vc_resp on read hit
pmem_read  out  1  physical memory read, held until pmem_resp
pmem_address  out  ADDR_W  physical memory address
pmem_rdata  in  LINE_W  valid with pmem_resp
pmem_resp  in  1  physical memory completion
vc_hit_count  out  CNT_W  saturating count of VC probe hits
vc_miss_count  out  CNT_W  saturating count of VC probe misses

Behaviour:
- Reset (rst_n low, asynchronous):
  - state goes to IDLE;
  - every output is 0, including both counters and the latched address/data registers;
  - a transaction interrupted by reset is abandoned, with no fill and no resumption;
  - request strobes drop combinationally with reset.
- States: IDLE, EVICT, PROBE, PMEM, FILL. State is registered; all outputs are Moore-decoded from state and the latched registers.
- IDLE:
  - if miss_req=1 at the clock edge, latch miss_addr, evict_valid, evict_addr, evict_data and evict_dirty;
  - go to EVICT if evict_valid=1, else PROBE;
  - miss_req=0 → stay in IDLE.
- EVICT:
  - drives vc_write=1, vc_addr=latched evict_addr, vc_wdata=latched evict_data, vc_wdirty=latched evict_dirty;
  - on an edge with vc_resp=1 → PROBE;
  - eviction always completes before the probe.
- PROBE:
  - drives vc_read=1, vc_addr=latched miss_addr;
  - on an edge with vc_resp=1:
    - vc_hit=1 → latch vc_rdata and vc_rdirty, increment vc_hit_count, go to FILL;
    - vc_hit=0 → increment vc_miss_count, go to PMEM.
- PMEM:
  - drives pmem_read=1, pmem_address=latched miss_addr;
  - on an edge with pmem_resp=1 → latch pmem_rdata, clear the latched dirty flag, go to FILL.
- FILL:
  - fill_valid=1 for exactly one cycle, with fill_data and fill_dirty driven from the latch;
  - unconditionally → IDLE.
- New-request timing: a miss_req seen in the FILL cycle is ignored. It is accepted on the first edge back in IDLE, so the earliest back-to-back acceptance is every 3 cycles.
- Minimum latency, counted from the accepting edge E0 (fill_valid high in the cycle after edge E):
  - VC hit, no evict, zero-wait vc_resp: fill_valid after E1;
  - with evict: fill_valid after E2;
  - pmem path: fill_valid after E(2+k), where k = cycles until pmem_resp.
- Strobe exclusivity: vc_read, vc_write and pmem_read are mutually exclusive and never high in IDLE or FILL.
- Address and data stability: vc_addr, vc_wdata and pmem_address are stable for the whole time their strobe is high.
- Responses outside their state: vc_resp and pmem_resp are ignored unless the matching strobe is high.
- Counters: saturate at all-ones and do not wrap; an increment at max holds the value.
- Ownership: the VC owns exclusivity (invalidating an entry on a read hit); this block never issues an invalidate.

Test Plan:
- Reset mid-PMEM: rst_n low while pmem_read=1 → pmem_read=0 immediately; busy=0; counters=0; no fill_valid afterwards.
- Miss without victim, VC hit: miss_addr=0x1230, evict_valid=0, VC returns vc_resp=1 with vc_hit=1, rdata=0xA5..A5, rdirty=1 in the same cycle → fill_valid one cycle later with fill_data=0xA5..A5 and fill_dirty=1; vc_hit_count=1.
- Miss with dirty victim, VC miss: evict 0x4560 dirty, miss 0x1230 → vc_write at 0x4560 with vc_wdirty=1 first, then vc_read at 0x1230 (vc_hit=0), then pmem_read at 0x1230 with pmem_resp after 5 cycles → fill with pmem_rdata and fill_dirty=0; vc_miss_count=1.
- Stalled VC: vc_resp held low 4 cycles in EVICT → vc_write, vc_addr and vc_wdata remain constant all 4 cycles; no vc_read until the EVICT edge that sees vc_resp=1.
- Spurious/extra requests: pmem_resp pulse in IDLE → no state change; miss_req held high through FILL → second transaction accepted on the first IDLE edge only, with exactly one fill per accepted request.
- Saturation: preload via 65535 hits, then 2 more hits → vc_hit_count=0xFFFF; vc_miss_count unchanged.

Source files
------------

// File: rtl/l2_vc_requester_if.sv
// Memory-side bus of the L2 miss requester: victim cache request/response
// channel and the physical memory read channel.
interface l2_vc_requester_if #(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 128
);
    logic              vc_write;
    logic              vc_read;
    logic [ADDR_W-1:0] vc_addr;
    logic [LINE_W-1:0] vc_wdata;
    logic              vc_wdirty;
    logic              vc_resp;
    logic              vc_hit;
    logic [LINE_W-1:0] vc_rdata;
    logic              vc_rdirty;
    logic              pmem_read;
    logic [ADDR_W-1:0] pmem_address;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;

    modport master (
        output vc_write, vc_read, vc_addr, vc_wdata, vc_wdirty, pmem_read, pmem_address,
        input  vc_resp, vc_hit, vc_rdata, vc_rdirty, pmem_rdata, pmem_resp
    );

    modport slave (
        input  vc_write, vc_read, vc_addr, vc_wdata, vc_wdirty, pmem_read, pmem_address,
        output vc_resp, vc_hit, vc_rdata, vc_rdirty, pmem_rdata, pmem_resp
    );
endinterface

// File: rtl/l2_vc_requester.sv
// L2 miss handler: pushes the victim line into the victim cache, probes the
// victim cache for the missing line, falls back to physical memory, then
// hands the line back to L2 as a one-cycle fill. Keeps saturating VC stats.
module l2_vc_requester #(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 128,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              miss_req,
    input  logic [ADDR_W-1:0] miss_addr,
    input  logic              evict_valid,
    input  logic [ADDR_W-1:0] evict_addr,
    input  logic [LINE_W-1:0] evict_data,
    input  logic              evict_dirty,
    output logic              busy,
    output logic              fill_valid,
    output logic [LINE_W-1:0] fill_data,
    output logic              fill_dirty,
    output logic [CNT_W-1:0]  vc_hit_count,
    output logic [CNT_W-1:0]  vc_miss_count,
    l2_vc_requester_if.master bus
);
    typedef enum logic [2:0] {IDLE, EVICT, PROBE, PMEM, FILL} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] ev_addr_q;
    logic [LINE_W-1:0] ev_data_q;
    logic              ev_dirty_q;
    logic [LINE_W-1:0] line_q;
    logic              dirty_q;
    logic [CNT_W-1:0]  hit_cnt, miss_cnt;

    wire probe_done = (state == PROBE) && bus.vc_resp;

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state: eviction always precedes the probe, responses only count
    // in the state that owns the matching strobe.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (miss_req) state_nxt = evict_valid ? EVICT : PROBE;
            EVICT: if (bus.vc_resp) state_nxt = PROBE;
            PROBE: if (bus.vc_resp) state_nxt = bus.vc_hit ? FILL : PMEM;
            PMEM:  if (bus.pmem_resp) state_nxt = FILL;
            FILL:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request capture in IDLE and line capture from the VC or memory.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q     <= '0;
            ev_addr_q  <= '0;
            ev_data_q  <= '0;
            ev_dirty_q <= 1'b0;
            line_q     <= '0;
            dirty_q    <= 1'b0;
        end else begin
            if (state == IDLE && miss_req) begin
                addr_q     <= miss_addr;
                ev_addr_q  <= evict_addr;
                ev_data_q  <= evict_data;
                ev_dirty_q <= evict_dirty;
            end
            if (probe_done && bus.vc_hit) begin
                line_q  <= bus.vc_rdata;
                dirty_q <= bus.vc_rdirty;
            end
            // A line from memory is always clean.
            if (state == PMEM && bus.pmem_resp) begin
                line_q  <= bus.pmem_rdata;
                dirty_q <= 1'b0;
            end
        end
    end

    // Probe statistics, held at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (probe_done) begin
            if (bus.vc_hit) begin
                if (hit_cnt != '1) hit_cnt <= hit_cnt + CNT_W'(1);
            end else begin
                if (miss_cnt != '1) miss_cnt <= miss_cnt + CNT_W'(1);
            end
        end
    end

    // Moore outputs: strobes are one-hot by state, addresses come from latches
    // so they stay stable for as long as the strobe is held.
    assign busy             = (state != IDLE);
    assign fill_valid       = (state == FILL);
    assign fill_data        = line_q;
    assign fill_dirty       = dirty_q;
    assign bus.vc_write     = (state == EVICT);
    assign bus.vc_read      = (state == PROBE);
    assign bus.vc_addr      = (state == EVICT) ? ev_addr_q :
                              (state == PROBE) ? addr_q : '0;
    assign bus.vc_wdata     = ev_data_q;
    assign bus.vc_wdirty    = ev_dirty_q;
    assign bus.pmem_read    = (state == PMEM);
    assign bus.pmem_address = addr_q;
    assign vc_hit_count     = hit_cnt;
    assign vc_miss_count    = miss_cnt;
endmodule

// File: tb/tb_l2_vc_requester.sv
// Directed bench for l2_vc_requester. Counters are built 4 bits wide here so
// saturation is reachable in a short run.
module tb_l2_vc_requester;
    localparam int ADDR_W = 16;
    localparam int LINE_W = 128;
    localparam int CNT_W  = 4;

    logic              clk;
    logic              rst_n;
    logic              miss_req;
    logic [ADDR_W-1:0] miss_addr;
    logic              evict_valid;
    logic [ADDR_W-1:0] evict_addr;
    logic [LINE_W-1:0] evict_data;
    logic              evict_dirty;
    logic              busy;
    logic              fill_valid;
    logic [LINE_W-1:0] fill_data;
    logic              fill_dirty;
    logic [CNT_W-1:0]  vc_hit_count;
    logic [CNT_W-1:0]  vc_miss_count;

    int n_chk  = 0;
    int n_pass = 0;

    l2_vc_requester_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

    l2_vc_requester #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .miss_req      (miss_req),
        .miss_addr     (miss_addr),
        .evict_valid   (evict_valid),
        .evict_addr    (evict_addr),
        .evict_data    (evict_data),
        .evict_dirty   (evict_dirty),
        .busy          (busy),
        .fill_valid    (fill_valid),
        .fill_data     (fill_data),
        .fill_dirty    (fill_dirty),
        .vc_hit_count  (vc_hit_count),
        .vc_miss_count (vc_miss_count),
        .bus           (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Zero-wait VC hit without a victim: accept, probe, fill, back to idle.
    task automatic do_hit(input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] d);
        miss_req = 1'b1; miss_addr = a; evict_valid = 1'b0;
        bus.vc_resp = 1'b1; bus.vc_hit = 1'b1; bus.vc_rdata = d; bus.vc_rdirty = 1'b0;
        step();
        miss_req = 1'b0;
        step();
        chk("sat_fill", {127'd0, fill_valid}, 128'd1);
        step();
        bus.vc_resp = 1'b0; bus.vc_hit = 1'b0;
    endtask

    logic [LINE_W-1:0] pat_a5, pat_ev, pat_pm, pat_st, pat_hd;
    int fills;

    initial begin
        pat_a5 = {16{8'hA5}};
        pat_ev = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
        pat_pm = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        pat_st = 128'hCAFE_F00D_1357_9BDF_2468_ACE0_0F0F_F0F0;
        pat_hd = 128'h5A5A_5A5A_0000_0000_FFFF_FFFF_1234_5678;

        rst_n = 1'b0; miss_req = 1'b0; miss_addr = '0; evict_valid = 1'b0;
        evict_addr = '0; evict_data = '0; evict_dirty = 1'b0;
        bus.vc_resp = 1'b0; bus.vc_hit = 1'b0; bus.vc_rdata = '0; bus.vc_rdirty = 1'b0;
        bus.pmem_rdata = '0; bus.pmem_resp = 1'b0;
        step();
        chk("rst_busy", {127'd0, busy}, 128'd0);
        chk("rst_strobes", {125'd0, bus.vc_write, bus.vc_read, bus.pmem_read}, 128'd0);
        chk("rst_fill", {127'd0, fill_valid}, 128'd0);
        chk("rst_cnt", {120'd0, vc_hit_count, vc_miss_count}, 128'd0);
        rst_n = 1'b1;
        step();

        // VC hit, no victim, response in the first probe cycle.
        miss_req = 1'b1; miss_addr = 16'h1230; evict_valid = 1'b0;
        bus.vc_resp = 1'b1; bus.vc_hit = 1'b1; bus.vc_rdata = pat_a5; bus.vc_rdirty = 1'b1;
        step();
        miss_req = 1'b0;
        chk("hit_busy", {127'd0, busy}, 128'd1);
        chk("hit_rd", {126'd0, bus.vc_read, bus.vc_write}, 128'd2);
        chk("hit_addr", {112'd0, bus.vc_addr}, 128'h1230);
        step();
        bus.vc_resp = 1'b0; bus.vc_hit = 1'b0;
        chk("hit_fv", {127'd0, fill_valid}, 128'd1);
        chk("hit_fdata", fill_data, pat_a5);
        chk("hit_fdirty", {127'd0, fill_dirty}, 128'd1);
        chk("hit_cnt", {124'd0, vc_hit_count}, 128'd1);
        chk("hit_nord", {127'd0, bus.vc_read}, 128'd0);
        step();
        chk("hit_idle", {126'd0, busy, fill_valid}, 128'd0);

        // Dirty victim, VC miss, memory answers after 5 cycles.
        miss_req = 1'b1; miss_addr = 16'h1230; evict_valid = 1'b1;
        evict_addr = 16'h4560; evict_data = pat_ev; evict_dirty = 1'b1;
        step();
        miss_req = 1'b0; evict_valid = 1'b0; evict_data = '0; evict_addr = '0;
        chk("ev_wr", {125'd0, bus.vc_write, bus.vc_read, bus.pmem_read}, 128'd4);
        chk("ev_addr", {112'd0, bus.vc_addr}, 128'h4560);
        chk("ev_wdata", bus.vc_wdata, pat_ev);
        chk("ev_wdirty", {127'd0, bus.vc_wdirty}, 128'd1);
        bus.vc_resp = 1'b1; bus.vc_hit = 1'b0;
        step();
        chk("ev_probe", {125'd0, bus.vc_write, bus.vc_read, bus.pmem_read}, 128'd2);
        chk("ev_paddr", {112'd0, bus.vc_addr}, 128'h1230);
        step();
        bus.vc_resp = 1'b0;
        chk("pm_rd", {125'd0, bus.vc_write, bus.vc_read, bus.pmem_read}, 128'd1);
        chk("pm_addr", {112'd0, bus.pmem_address}, 128'h1230);
        chk("pm_miss_cnt", {120'd0, vc_hit_count, vc_miss_count}, 128'h11);
        for (int i = 0; i < 4; i++) step();
        chk("pm_wait", {126'd0, bus.pmem_read, fill_valid}, 128'd2);
        bus.pmem_resp = 1'b1; bus.pmem_rdata = pat_pm;
        step();
        bus.pmem_resp = 1'b0; bus.pmem_rdata = '0;
        chk("pm_fv", {126'd0, fill_valid, bus.pmem_read}, 128'd2);
        chk("pm_fdata", fill_data, pat_pm);
        chk("pm_fdirty", {127'd0, fill_dirty}, 128'd0);
        step();
        chk("pm_idle", {127'd0, busy}, 128'd0);

        // Reset while waiting on memory.
        miss_req = 1'b1; miss_addr = 16'h0ab0; evict_valid = 1'b0;
        bus.vc_resp = 1'b1; bus.vc_hit = 1'b0;
        step();
        miss_req = 1'b0;
        step();
        bus.vc_resp = 1'b0;
        chk("rp_pmem", {127'd0, bus.pmem_read}, 128'd1);
        rst_n = 1'b0;
        #1;
        chk("rp_drop", {125'd0, bus.pmem_read, busy, fill_valid}, 128'd0);
        chk("rp_cnt", {120'd0, vc_hit_count, vc_miss_count}, 128'd0);
        bus.pmem_resp = 1'b1; bus.pmem_rdata = pat_pm;
        step();
        rst_n = 1'b1;
        fills = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (fill_valid) fills++;
        end
        bus.pmem_resp = 1'b0;
        chk("rp_nofill", 128'(fills), 128'd0);
        chk("rp_idle", {127'd0, busy}, 128'd0);

        // VC stalls four cycles on the eviction.
        miss_req = 1'b1; miss_addr = 16'h2340; evict_valid = 1'b1;
        evict_addr = 16'h7770; evict_data = pat_st; evict_dirty = 1'b0;
        step();
        miss_req = 1'b0; evict_valid = 1'b0; evict_data = '0; evict_addr = '0;
        for (int i = 0; i < 4; i++) begin
            chk("st_wr", {126'd0, bus.vc_write, bus.vc_read}, 128'd2);
            chk("st_addr", {112'd0, bus.vc_addr}, 128'h7770);
            chk("st_wdata", bus.vc_wdata, pat_st);
            if (i < 3) step();
        end
        bus.vc_resp = 1'b1; bus.vc_hit = 1'b1; bus.vc_rdata = pat_hd; bus.vc_rdirty = 1'b0;
        step();
        chk("st_probe", {126'd0, bus.vc_write, bus.vc_read}, 128'd1);
        chk("st_paddr", {112'd0, bus.vc_addr}, 128'h2340);
        step();
        bus.vc_resp = 1'b0; bus.vc_hit = 1'b0;
        chk("st_fdata", fill_data, pat_hd);
        step();

        // Spurious memory response in idle, then miss_req held through fill.
        bus.pmem_resp = 1'b1;
        step();
        bus.pmem_resp = 1'b0;
        chk("sp_idle", {124'd0, busy, fill_valid, bus.pmem_read, bus.vc_read}, 128'd0);
        miss_req = 1'b1; miss_addr = 16'h3450; evict_valid = 1'b0;
        bus.vc_resp = 1'b1; bus.vc_hit = 1'b1; bus.vc_rdata = pat_a5; bus.vc_rdirty = 1'b0;
        fills = 0;
        step();                                   // PROBE
        step(); if (fill_valid) fills++;          // FILL, request ignored
        step(); if (fill_valid) fills++;
        chk("sp_back_idle", {127'd0, busy}, 128'd0);
        step(); if (fill_valid) fills++;          // second request accepted
        chk("sp_accept", {126'd0, busy, bus.vc_read}, 128'd3);
        miss_req = 1'b0;
        step(); if (fill_valid) fills++;
        step(); if (fill_valid) fills++;
        step(); if (fill_valid) fills++;
        bus.vc_resp = 1'b0; bus.vc_hit = 1'b0;
        chk("sp_fills", 128'(fills), 128'd2);
        chk("sp_hits", {124'd0, vc_hit_count}, 128'd3);

        // Drive the hit counter to all-ones, then past it.
        for (int i = 0; i < 12; i++) do_hit(16'h5000 + 16'(i * 16), pat_hd);
        chk("sat_max", {124'd0, vc_hit_count}, 128'hF);
        do_hit(16'h6000, pat_hd);
        do_hit(16'h6010, pat_hd);
        chk("sat_hold", {124'd0, vc_hit_count}, 128'hF);
        chk("sat_miss", {124'd0, vc_miss_count}, 128'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
